// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte sequencer.
//   SPI_BYTE_W      : width of one SPI transfer byte
//   spi_seq_state_t : sequencer FSM states
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StGap
  } spi_seq_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : drop head entry (ignored when empty)
//   rdata_o    : head entry, zero while empty
//   full_o     : level == DEPTH
//   empty_o    : level == 0
//   level_o    : occupancy 0..DEPTH
module spi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              push_ok, pop_ok;

  assign full_o  = (level_q == LevelW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // A full FIFO refuses the push but still pops; an empty one refuses the pop.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/spi_byte_sequencer.sv
// Byte-stream front end for an SPI master: buffers TX bytes, issues one
// start pulse per byte, waits out the master's busy window, captures the
// received byte and inserts a fixed idle gap between transfers.
// Optional feature macro: SPI_BYTE_SEQUENCER_RX_EN (RX FIFO and m_* stream).
//   s_valid/s_ready/s_data    : TX byte stream in
//   m_valid/m_ready/m_data    : RX byte stream out (constant 0 without RX)
//   spi_start/spi_data_in     : start pulse and byte to the master
//   spi_busy/spi_data_out     : master busy flag and received byte
//   tx_level/rx_level         : FIFO occupancies
//   idle                      : FSM idle with TX FIFO empty
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [SPI_BYTE_W-1:0]  s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [SPI_BYTE_W-1:0]  m_data,
  output logic                   spi_start,
  output logic [SPI_BYTE_W-1:0]  spi_data_in,
  input  logic                   spi_busy,
  input  logic [SPI_BYTE_W-1:0]  spi_data_out,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   idle
);

  localparam logic [7:0] GapLast = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  spi_seq_state_t        state_q, state_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic [SPI_BYTE_W-1:0] data_in_q;

  logic                  tx_pop, tx_full, tx_empty;
  logic [SPI_BYTE_W-1:0] tx_head;
  logic                  rx_push, rx_free;

  spi_sync_fifo #(
    .WIDTH (SPI_BYTE_W),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s_valid),
    .wdata_i (s_data),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  assign s_ready = ~tx_full;

`ifdef SPI_BYTE_SEQUENCER_RX_EN
  logic rx_full, rx_empty;

  spi_sync_fifo #(
    .WIDTH (SPI_BYTE_W),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .wdata_i (spi_data_out),
    .pop_i   (m_ready),
    .rdata_o (m_data),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

  assign m_valid = ~rx_empty;
  // Never start a transfer whose result would have nowhere to go.
  assign rx_free = ~rx_full;
`else
  logic unused_rx;
  assign unused_rx = ^{m_ready, spi_data_out, rx_push};
  assign m_valid   = 1'b0;
  assign m_data    = '0;
  assign rx_level  = '0;
  assign rx_free   = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gap_cnt_q <= '0;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      // Keep the last issued byte on spi_data_in outside ISSUE.
      if (tx_pop) begin
        data_in_q <= tx_head;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!tx_empty && rx_free) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (spi_busy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!spi_busy) begin
          state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          gap_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = StIdle;
        gap_cnt_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    spi_start   = (state_q == StIssue);
    tx_pop      = (state_q == StIssue);
    rx_push     = (state_q == StWaitDone) && !spi_busy;
    spi_data_in = (state_q == StIssue) ? tx_head : data_in_q;
    idle        = (state_q == StIdle) && tx_empty;
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
module tb_spi_byte_sequencer;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned GAP_CYCLES = 2;
  localparam int unsigned LW         = $clog2(DEPTH) + 1;
`ifdef SPI_BYTE_SEQUENCER_RX_EN
  localparam bit RxEn = 1'b1;
`else
  localparam bit RxEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'h00;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [7:0]    m_data;
  logic          spi_start;
  logic [7:0]    spi_data_in;
  logic          spi_busy = 1'b0;
  logic [7:0]    spi_data_out = 8'h00;
  logic [LW-1:0] tx_level, rx_level;
  logic          idle;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_byte_sequencer #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_busy     (spi_busy),
    .spi_data_out (spi_data_out),
    .tx_level     (tx_level),
    .rx_level     (rx_level),
    .idle         (idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte queues, transfer bookkeeping, counters.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         cyc       = 0;
  int         last_fall = -1000;
  int         n_starts  = 0;
  int         n_push    = 0;
  bit         in_xfer   = 0;
  bit         busy_hi   = 0;
  bit         prev_start = 0;
  bit         can_push;
  logic [7:0] mask      = 8'h00;
  int         force_len = 0;

  // Monitor: compare at negedge, then apply the events of the next posedge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      tx_q.delete();
      rx_q.delete();
      in_xfer    = 0;
      busy_hi    = 0;
      prev_start = 0;
      last_fall  = -1000;
    end else begin
      check("tx_level", tx_level, tx_q.size());
      check("s_ready", s_ready, tx_q.size() < DEPTH);
      check("rx_level", rx_level, rx_q.size());
      check("m_valid", m_valid, rx_q.size() != 0);
      check("m_data", m_data, (rx_q.size() != 0) ? rx_q[0] : 8'h00);
      if (spi_start) begin
        check("start_width", prev_start, 0);
        check("issue_nonempty", tx_q.size() != 0, 1);
        if (tx_q.size() != 0) check("spi_data_in", spi_data_in, tx_q[0]);
        check("start_spacing", (cyc - last_fall) >= (int'(GAP_CYCLES) + 2), 1);
`ifdef SPI_BYTE_SEQUENCER_RX_EN
        check("issue_rx_room", rx_q.size() < DEPTH, 1);
`endif
        n_starts++;
      end
      if (m_ready && rx_q.size() != 0) void'(rx_q.pop_front());
      if (in_xfer && busy_hi && !spi_busy) begin
`ifdef SPI_BYTE_SEQUENCER_RX_EN
        rx_q.push_back(spi_data_out);
`endif
        last_fall = cyc;
        in_xfer   = 0;
        busy_hi   = 0;
      end else if (in_xfer && spi_busy) begin
        busy_hi = 1;
      end
      can_push = tx_q.size() < DEPTH;
      if (spi_start && tx_q.size() != 0) begin
        void'(tx_q.pop_front());
        in_xfer = 1;
      end
      if (s_valid && can_push) begin
        tx_q.push_back(s_data);
        n_push++;
      end
      prev_start = spi_start;
    end
  end

  // SPI master model: busy after 1..3 clocks, for 1..6 clocks, returns byte ^ mask.
  logic [7:0] mb;
  int         md, ml;
  bit         mok;
  always begin
    @(negedge clk);
    if (rst_n && spi_start) begin
      mb = spi_data_in;
      md = $urandom_range(1, 3);
      ml = (force_len != 0) ? force_len : $urandom_range(1, 6);
      @(posedge clk);
      mok = rst_n;
      for (int i = 1; i < md && mok; i++) begin
        @(posedge clk);
        mok = rst_n;
      end
      #1;
      if (mok) spi_busy = 1'b1;
      for (int i = 0; i < ml && mok; i++) begin
        @(posedge clk);
        mok = rst_n;
      end
      #1;
      if (mok) spi_data_out = mb ^ mask;
      spi_busy = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) check("push_timeout", 0, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while (!(idle && !in_xfer && tx_q.size() == 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) check(tag, 0, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    m_ready = 1'b1;
    while (rx_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check(tag, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st0, p0, n;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_data_in", spi_data_in, 0);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_idle", idle, 1);
    rst_n = 1'b1;
    tick();

    // Single byte loopback, start latency, push+pop with one entry
    mask = 8'h00;
    m_ready = 1'b0;
    st0 = n_starts;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    tick();                       // edge N: push
    s_valid = 1'b0;
    @(negedge clk);
    check("lat_before", spi_start, 0);
    tick();                       // edge N+1: IDLE -> ISSUE
    s_valid = 1'b1;
    s_data  = 8'h5B;
    @(negedge clk);
    check("lat_start", spi_start, 1);
    check("lat_data", spi_data_in, 8'hA5);
    tick();                       // edge N+2: pop and push together
    s_valid = 1'b0;
    @(negedge clk);
    check("tx_pushpop_one", tx_level, 1);
    wait_quiet("q_single");
    check("single_starts", n_starts - st0, 2);
    check("single_idle", idle, 1);
    check("single_rx_level", rx_level, RxEn ? 2 : 0);
    drain("drain_single");

    // Stall on RX full (RX build) or run through (no RX build)
    m_ready = 1'b0;
    st0 = n_starts;
    for (int i = 1; i <= 2 * DEPTH; i++) push_byte(8'(i));
    repeat (100) tick();
    check("stall_starts", n_starts - st0, RxEn ? DEPTH : 2 * DEPTH);
    check("stall_rx_level", rx_level, RxEn ? DEPTH : 0);
    check("stall_m_valid", m_valid, RxEn);
`ifdef SPI_BYTE_SEQUENCER_RX_EN
    check("stall_tx_full", s_ready, 0);
    check("stall_idle", idle, 0);
    s_valid = 1'b1;
    s_data  = 8'h77;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!spi_start && n < 50);
    check("release_seen", spi_start, 1);
    check("full_pop_s_ready", s_ready, 0);
    check("full_pop_before", tx_level, DEPTH);
    @(negedge clk);
    check("full_pop_after", tx_level, DEPTH - 1);
    tick();
    s_valid = 1'b0;
    repeat (100) tick();
    check("release_starts", n_starts - st0, DEPTH + 1);
`endif
    drain("drain_stall_a");
    wait_quiet("q_stall");
    drain("drain_stall_b");
    check("stall_total", n_starts - st0, RxEn ? 2 * DEPTH + 1 : 2 * DEPTH);

    // Reset in the middle of a transfer
    m_ready   = 1'b0;
    force_len = 30;
    st0 = n_starts;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    n = 0;
    while (!(n_starts - st0 == 2 && busy_hi) && n < 500) begin
      tick();
      n++;
    end
    check("rst_mid_reached", n_starts - st0, 2);
    tick();                       // now waiting for busy to fall
    rst_n = 1'b0;
    #1;
    check("arst_s_ready", s_ready, 1);
    check("arst_m_valid", m_valid, 0);
    check("arst_m_data", m_data, 0);
    check("arst_spi_start", spi_start, 0);
    check("arst_spi_data_in", spi_data_in, 0);
    check("arst_tx_level", tx_level, 0);
    check("arst_rx_level", rx_level, 0);
    check("arst_idle", idle, 1);
    tick();
    tick();
    rst_n     = 1'b1;
    force_len = 0;
    tick();
    check("post_rst_tx_level", tx_level, 0);
    check("post_rst_rx_level", rx_level, 0);
    st0 = n_starts;
    push_byte(8'h3C);
    m_ready = 1'b1;
    wait_quiet("q_post_rst");
    drain("drain_post_rst");
    check("post_rst_starts", n_starts - st0, 1);
    check("post_rst_idle", idle, 1);

    // Randomized traffic
    mask = 8'($urandom_range(1, 255));
    st0 = n_starts;
    p0  = n_push;
    for (int i = 0; i < 600; i++) begin
      s_valid = ($urandom_range(0, 2) == 0);
      s_data  = 8'($urandom);
      m_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    s_valid = 1'b0;
    drain("drain_rand_a");
    wait_quiet("q_rand");
    drain("drain_rand_b");
    check("rand_all_issued", n_starts - st0, n_push - p0);
    check("rand_idle", idle, 1);
    check("rand_rx_level", rx_level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
